// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - score memory, tick timebase and playback FSM driving synthesizer keycodes
module song_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int PRESCALE = 50000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] score_address,
    input  logic              score_write,
    input  logic [31:0]       score_writedata,
    output logic [31:0]       score_readdata,
    input  logic [1:0]        ctrl_address,
    input  logic              ctrl_write,
    input  logic [15:0]       ctrl_writedata,
    output logic [15:0]       ctrl_readdata,
    output logic [31:0]       song,
    output logic              playing
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_NOTE, S_GAP} state_t;

    logic [31:0]       score_mem [DEPTH];
    state_t            state;
    logic [15:0]       tempo;
    logic [15:0]       tempo_cur;
    logic [15:0]       gap_len;
    logic              loop_en;
    logic [ADDR_W-1:0] position;
    logic [31:0]       entry;
    logic [15:0]       remaining;
    logic [PW-1:0]     pre_cnt;
    logic [15:0]       unit_cnt;

    logic [15:0] tempo_eff;
    logic        timing;
    logic        pre_wrap;
    logic        unit_wrap;
    logic        tick;
    logic        last_pos;
    logic        ctl_wr;
    logic [7:0]  pos8;

    // Score RAM is deliberately left out of reset so a stored song survives it.
    always_ff @(posedge CLK) begin
        if (score_write)
            score_mem[score_address] <= score_writedata;
    end

    assign score_readdata = score_mem[score_address];

    assign tempo_eff = (tempo == 16'd0) ? 16'd1 : tempo;
    assign timing    = (state == S_NOTE) || (state == S_GAP);
    assign pre_wrap  = (pre_cnt == PW'(PRESCALE - 1));
    assign unit_wrap = (unit_cnt == tempo_cur - 16'd1);
    assign tick      = timing && pre_wrap && unit_wrap;
    assign last_pos  = (position == {ADDR_W{1'b1}});
    assign ctl_wr    = ctrl_write && (ctrl_address == 2'd0);
    assign pos8      = 8'(position);

    always_comb begin
        ctrl_readdata = 16'd0;
        case (ctrl_address)
            2'd0: ctrl_readdata = {13'd0, loop_en, 2'b00};
            2'd1: ctrl_readdata = tempo;
            2'd2: ctrl_readdata = {pos8, 7'd0, playing};
            2'd3: ctrl_readdata = gap_len;
            default: ctrl_readdata = 16'd0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            song      <= 32'd0;
            playing   <= 1'b0;
            tempo     <= 16'd1;
            tempo_cur <= 16'd1;
            gap_len   <= 16'd1;
            loop_en   <= 1'b0;
            position  <= '0;
            entry     <= 32'd0;
            remaining <= 16'd0;
            pre_cnt   <= '0;
            unit_cnt  <= 16'd0;
        end else begin
            if (ctrl_write) begin
                case (ctrl_address)
                    2'd0: loop_en <= ctrl_writedata[2];
                    2'd1: tempo   <= ctrl_writedata;
                    2'd3: gap_len <= ctrl_writedata;
                    default: ;
                endcase
            end

            if (timing) begin
                if (pre_wrap) begin
                    pre_cnt <= '0;
                    if (unit_wrap) begin
                        unit_cnt  <= 16'd0;
                        tempo_cur <= tempo_eff;
                    end else begin
                        unit_cnt <= unit_cnt + 16'd1;
                    end
                end else begin
                    pre_cnt <= pre_cnt + PW'(1);
                end
            end

            // A CONTROL write overrides whatever the FSM would do this cycle; stop beats play.
            if (ctl_wr && ctrl_writedata[1]) begin
                state   <= S_IDLE;
                playing <= 1'b0;
                song    <= 32'd0;
            end else if (ctl_wr && ctrl_writedata[0]) begin
                state    <= S_FETCH;
                playing  <= 1'b1;
                position <= '0;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_FETCH: begin
                        entry <= score_mem[position];
                        state <= S_LATCH;
                    end
                    S_LATCH: begin
                        if (entry[31:24] == 8'd0) begin
                            if (loop_en) begin
                                position <= '0;
                                state    <= S_FETCH;
                            end else begin
                                song    <= 32'd0;
                                playing <= 1'b0;
                                state   <= S_IDLE;
                            end
                        end else begin
                            song      <= {8'h00, entry[23:0]};
                            remaining <= {8'h00, entry[31:24]};
                            pre_cnt   <= '0;
                            unit_cnt  <= 16'd0;
                            tempo_cur <= tempo_eff;
                            state     <= S_NOTE;
                        end
                    end
                    S_NOTE, S_GAP: begin
                        if (tick) begin
                            if (remaining != 16'd1) begin
                                remaining <= remaining - 16'd1;
                            end else if (state == S_NOTE && gap_len != 16'd0) begin
                                song      <= 32'd0;
                                remaining <= gap_len;
                                pre_cnt   <= '0;
                                unit_cnt  <= 16'd0;
                                state     <= S_GAP;
                            end else if (!last_pos) begin
                                position <= position + ADDR_W'(1);
                                state    <= S_FETCH;
                            end else if (loop_en) begin
                                position <= '0;
                                state    <= S_FETCH;
                            end else begin
                                song    <= 32'd0;
                                playing <= 1'b0;
                                state   <= S_IDLE;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - register vectors, timeline model of playback and corner-case sequences
module tb_song_sequencer;

    localparam int AW = 2;
    localparam int P  = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [AW-1:0] score_address = '0;
    logic          score_write = 1'b0;
    logic [31:0]   score_writedata = 32'd0;
    logic [31:0]   score_readdata;
    logic [1:0]    ctrl_address = 2'd2;
    logic          ctrl_write = 1'b0;
    logic [15:0]   ctrl_writedata = 16'd0;
    logic [15:0]   ctrl_readdata;
    logic [31:0]   song;
    logic          playing;

    song_sequencer #(.ADDR_W(AW), .PRESCALE(P)) dut (
        .CLK(CLK), .RESET(RESET),
        .score_address(score_address), .score_write(score_write),
        .score_writedata(score_writedata), .score_readdata(score_readdata),
        .ctrl_address(ctrl_address), .ctrl_write(ctrl_write),
        .ctrl_writedata(ctrl_writedata), .ctrl_readdata(ctrl_readdata),
        .song(song), .playing(playing)
    );

    always #5 CLK = ~CLK;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [31:0] sc [4];
    int m_tempo = 1;
    int m_gap   = 1;

    typedef struct {
        logic [31:0] song;
        logic        playing;
        int          pos;
    } samp_t;
    samp_t exp_q[$];

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } reg_vec_t;
    reg_vec_t vecs [13];

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic ctrl_wr(input logic [1:0] a, input logic [15:0] d);
        @(negedge CLK);
        ctrl_address   = a;
        ctrl_writedata = d;
        ctrl_write     = 1'b1;
        @(posedge CLK);
        #1;
        ctrl_write   = 1'b0;
        ctrl_address = 2'd2;
    endtask

    task automatic set_tempo(input int t);
        ctrl_wr(2'd1, 16'(t));
        m_tempo = t;
    endtask

    task automatic set_gap(input int g);
        ctrl_wr(2'd3, 16'(g));
        m_gap = g;
    endtask

    task automatic load_score(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        sc[0] = a; sc[1] = b; sc[2] = c; sc[3] = d;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            score_address   = AW'(i);
            score_writedata = sc[i];
            score_write     = 1'b1;
            @(posedge CLK);
            #1;
            score_write = 1'b0;
        end
    endtask

    function automatic void push(input logic [31:0] s, input logic pl, input int ps, input int n);
        samp_t x;
        x.song = s; x.playing = pl; x.pos = ps;
        for (int i = 0; i < n; i++) exp_q.push_back(x);
    endfunction

    // Expected per-cycle timeline, one entry per falling edge after the play write.
    task automatic build_model(input bit lp, input int cap);
        int pos;
        int tu;
        int d;
        logic [31:0] s;
        logic [31:0] e;
        exp_q.delete();
        pos = 0;
        s   = 32'd0;
        tu  = ((m_tempo == 0) ? 1 : m_tempo) * P;
        while (exp_q.size() < cap) begin
            push(s, 1'b1, pos, 2);
            e = sc[pos];
            d = int'(e[31:24]);
            if (d == 0) begin
                if (lp) begin
                    pos = 0;
                    continue;
                end
                push(32'd0, 1'b0, pos, 1);
                break;
            end
            s = {8'h00, e[23:0]};
            push(s, 1'b1, pos, d * tu);
            if (m_gap != 0) begin
                push(32'd0, 1'b1, pos, m_gap * tu);
                s = 32'd0;
            end
            if (pos == 3) begin
                if (lp) pos = 0;
                else begin
                    push(32'd0, 1'b0, pos, 1);
                    break;
                end
            end else begin
                pos++;
            end
        end
        while (exp_q.size() > cap) void'(exp_q.pop_back());
    endtask

    task automatic run(input bit lp, input int cap, input string name);
        logic [63:0] act;
        logic [63:0] exp;
        logic [63:0] mask;
        build_model(lp, cap);
        ctrl_wr(2'd0, lp ? 16'd5 : 16'd1);
        foreach (exp_q[i]) begin
            @(negedge CLK);
            act  = {15'd0, playing, ctrl_readdata, song};
            exp  = {15'd0, exp_q[i].playing, 8'(exp_q[i].pos), 7'd0, exp_q[i].playing, exp_q[i].song};
            mask = exp_q[i].playing ? {64{1'b1}} : {16'h0001, 16'h0001, 32'hFFFF_FFFF};
            check((act & mask) == (exp & mask), $sformatf("%s cyc%0d", name, i), act & mask, exp & mask);
            if ((act & mask) != (exp & mask)) break;
        end
        if (lp) begin
            ctrl_wr(2'd0, 16'd2);
            @(negedge CLK);
            check(song == 32'd0 && !playing, {name, " stop"}, {31'd0, playing, song}, 64'd0);
        end
    endtask

    initial begin
        vecs[0]  = '{2'd1, 1'b0, 16'h0000, 16'h0001};
        vecs[1]  = '{2'd3, 1'b0, 16'h0000, 16'h0001};
        vecs[2]  = '{2'd2, 1'b0, 16'h0000, 16'h0000};
        vecs[3]  = '{2'd0, 1'b0, 16'h0000, 16'h0000};
        vecs[4]  = '{2'd1, 1'b1, 16'h0000, 16'h0000};
        vecs[5]  = '{2'd1, 1'b1, 16'h1234, 16'h1234};
        vecs[6]  = '{2'd3, 1'b1, 16'h0000, 16'h0000};
        vecs[7]  = '{2'd3, 1'b1, 16'h0007, 16'h0007};
        vecs[8]  = '{2'd2, 1'b1, 16'hFFFF, 16'h0000};
        vecs[9]  = '{2'd0, 1'b1, 16'h0004, 16'h0004};
        vecs[10] = '{2'd0, 1'b1, 16'hFFFB, 16'h0000};
        vecs[11] = '{2'd2, 1'b0, 16'h0000, 16'h0000};
        vecs[12] = '{2'd0, 1'b1, 16'h0000, 16'h0000};

        repeat (3) @(negedge CLK);
        check(song == 32'd0 && !playing, "in reset", {31'd0, playing, song}, 64'd0);
        RESET = 1'b0;
        @(negedge CLK);
        check(song == 32'd0 && !playing, "after reset", {31'd0, playing, song}, 64'd0);

        foreach (vecs[i]) begin
            if (vecs[i].wr) ctrl_wr(vecs[i].addr, vecs[i].wdata);
            @(negedge CLK);
            ctrl_address = vecs[i].addr;
            #1;
            check(ctrl_readdata == vecs[i].exp, $sformatf("reg vec%0d", i), 64'(ctrl_readdata), 64'(vecs[i].exp));
            check(!playing, $sformatf("reg vec%0d idle", i), 64'(playing), 64'd0);
            ctrl_address = 2'd2;
        end

        load_score(32'h0300_0004, 32'h0216_0709, 32'h0000_0000, 32'h0100_00AA);
        score_address = 2'd1;
        #1;
        check(score_readdata == 32'h0216_0709, "score readback", 64'(score_readdata), 64'h0216_0709);
        set_tempo(2);
        set_gap(1);
        run(1'b0, 400, "basic");
        run(1'b1, 160, "loop");

        // Stop in the middle of a note, then play+stop together from idle.
        ctrl_wr(2'd0, 16'd1);
        repeat (8) @(negedge CLK);
        check(song == 32'h0000_0004 && playing, "mid note", {31'd0, playing, song}, {31'd0, 1'b1, 32'h4});
        ctrl_wr(2'd0, 16'd2);
        @(negedge CLK);
        check(song == 32'd0 && !playing, "stop mid note", {31'd0, playing, song}, 64'd0);
        ctrl_wr(2'd0, 16'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check(song == 32'd0 && !playing, "play+stop idle", {31'd0, playing, song}, 64'd0);
        end

        load_score(32'h0100_0004, 32'h0100_0004, 32'h0000_0000, 32'h0000_0000);
        set_gap(0);
        run(1'b0, 400, "gap0");
        set_gap(1);
        run(1'b0, 400, "gap1");

        load_score(32'h0100_0011, 32'h0200_0022, 32'h0100_0033, 32'h0100_0044);
        run(1'b0, 400, "wrap stop");
        run(1'b1, 200, "wrap loop");

        for (int r = 0; r < 20; r++) begin
            logic [31:0] e [4];
            for (int k = 0; k < 4; k++) begin
                e[k] = $urandom;
                e[k][31:24] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
                if ($urandom_range(0, 5) == 0) e[k][23:0] = 24'd0;
            end
            load_score(e[0], e[1], e[2], e[3]);
            set_tempo($urandom_range(0, 3));
            set_gap($urandom_range(0, 2));
            run(1'($urandom_range(0, 1)), 250, $sformatf("rand%0d", r));
        end

        // Asynchronous reset during a note clears the output before the next edge.
        load_score(32'h0300_0055, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        set_tempo(2);
        ctrl_wr(2'd0, 16'd1);
        repeat (6) @(negedge CLK);
        check(song == 32'h0000_0055 && playing, "pre reset note", {31'd0, playing, song}, {31'd0, 1'b1, 32'h55});
        #2 RESET = 1'b1;
        #1;
        check(song == 32'd0 && !playing, "async reset", {31'd0, playing, song}, 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        ctrl_address = 2'd1;
        #1;
        check(ctrl_readdata == 16'd1, "tempo after reset", 64'(ctrl_readdata), 64'd1);
        score_address = 2'd0;
        #1;
        check(score_readdata == 32'h0300_0055, "score kept", 64'(score_readdata), 64'h0300_0055);
        ctrl_address = 2'd2;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
